// File: rtl/mem_sub_word_ctrl_if.sv
// Bundle of MEM-stage request/response and word-memory bus signals.
// The slave side is the sequencer; the master side is the pipeline plus memory.
interface mem_sub_word_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_sub_word_ctrl.sv
// Byte/half/word load-store sequencer over a word-wide, big-endian data memory.
// Sub-word stores are done as read-modify-write; misalignment and ack timeouts report resp_err.
module mem_sub_word_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_sub_word_ctrl_if.slave   bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state_reg, state_next;
    logic              store_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;
    logic [WAIT_W-1:0] wait_reg;

    logic accept;
    logic bad_req;
    logic timeout;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        case (off)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   result = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   result = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] result;
        result = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    result[31:24] = data[7:0];
                    2'd1:    result[23:16] = data[7:0];
                    2'd2:    result[15:8]  = data[7:0];
                    default: result[7:0]   = data[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) result[15:0]  = data[15:0];
                else        result[31:16] = data[15:0];
            end
            default: result = data;
        endcase
        return result;
    endfunction

    assign accept  = bus.req_valid && (state_reg == IDLE);
    assign bad_req = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    // An ack in the final allowed cycle takes priority over the timeout.
    assign timeout = !bus.mem_ack && (wait_reg == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bad_req)                                    state_next = RESP;
                    else if (bus.req_store && bus.req_size == 2'b10) state_next = WR;
                    else                                            state_next = RD;
                end
            end
            RD: begin
                if (bus.mem_ack) state_next = store_reg ? WR : RESP;
                else if (timeout) state_next = RESP;
            end
            WR: begin
                if (bus.mem_ack || timeout) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_reg)
            IDLE: bus.req_ready = 1'b1;
            RD:   bus.mem_req   = 1'b1;
            WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
            end
            default: bus.resp_valid = 1'b1;
        endcase
    end

    assign bus.mem_addr   = addr_reg[31:2];
    assign bus.mem_wdata  = wdata_reg;
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_reg    <= 1'b0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            rdata_reg    <= 32'd0;
            err_reg      <= 1'b0;
            wait_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        store_reg    <= bus.req_store;
                        size_reg     <= bus.req_size;
                        unsigned_reg <= bus.req_unsigned;
                        addr_reg     <= bus.req_addr;
                        wdata_reg    <= bus.req_wdata;
                        wait_reg     <= '0;
                        if (bad_req) begin
                            rdata_reg <= 32'd0;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (bus.mem_ack) begin
                        wait_reg <= '0;
                        if (store_reg) begin
                            // The raw store data is consumed here and replaced by the merged word.
                            wdata_reg <= merge(bus.mem_rdata, wdata_reg, size_reg, addr_reg[1:0]);
                        end else begin
                            rdata_reg <= extract(bus.mem_rdata, size_reg, addr_reg[1:0], unsigned_reg);
                            err_reg   <= 1'b0;
                        end
                    end else if (timeout) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                WR: begin
                    if (bus.mem_ack) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b0;
                    end else if (timeout) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sub_word_ctrl.sv
// Bench for mem_sub_word_ctrl: directed vector table, random traffic against an arithmetic
// reference model, timeout and mid-operation reset sequences.
module tb_mem_sub_word_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sub_word_ctrl_if bus();
    mem_sub_word_ctrl_if bus2();

    mem_sub_word_ctrl #(.MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_sub_word_ctrl #(.MAX_WAIT(4)) dut_t (.clk(clk), .rst(rst), .bus(bus2));

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_words [256];
    logic [31:0] ref_words [256];
    int          wait_cycles = 0;
    int          resp_cnt = 0;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] pre;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nreq;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word memory: acks after wait_cycles non-ack cycles; wait_cycles < 0 never acks.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req && !rst) begin
                if (wait_cycles >= 0 && cnt >= wait_cycles) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        mem_words[bus.mem_addr[7:0]] = bus.mem_wdata;
                        bus.mem_rdata = $urandom;
                    end else begin
                        bus.mem_rdata = mem_words[bus.mem_addr[7:0]];
                    end
                    cnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    bus.mem_rdata = $urandom;
                    cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = $urandom;
                cnt = 0;
            end
        end
    end

    always @(posedge clk) if (bus.resp_valid) resp_cnt <= resp_cnt + 1;

    task automatic run_txn(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int w,
                           output int lat, output int nreq, output int nwe,
                           output logic [31:0] rd, output logic er, output logic addr_ok);
        wait_cycles = w;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_size = sz;
        bus.req_unsigned = uns;
        bus.req_addr = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_store = 1'($urandom);
        bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        lat = -1; nreq = 0; nwe = 0; rd = 32'd0; er = 1'b0; addr_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            if (bus.mem_req) begin
                nreq++;
                if (bus.mem_we) nwe++;
                if (bus.mem_addr !== a[31:2]) addr_ok = 1'b0;
            end
            if (bus.resp_valid) begin
                lat = k;
                rd = bus.resp_rdata;
                er = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: lane positions from shift arithmetic, updates ref_words for stores.
    task automatic model(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int w,
                         output logic [31:0] exp_rd, output logic exp_err,
                         output int exp_lat, output int exp_nreq);
        int unsigned off, shift, word, mask, v;
        off = a % 4;
        word = ref_words[(a / 4) % 256];
        exp_rd = 32'd0; exp_err = 1'b0;
        if (sz == 3 || (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0)) begin
            exp_err = 1'b1; exp_lat = 1; exp_nreq = 0;
        end else begin
            mask = (sz == 0) ? 32'hFF : 32'hFFFF;
            shift = (sz == 0) ? (3 - off) * 8 : (2 - off) * 8;
            if (!st) begin
                exp_lat = 2 + w; exp_nreq = w + 1;
                if (sz == 2) v = word;
                else begin
                    v = (word >> shift) & mask;
                    if (!uns && v > (mask >> 1)) v = v | ~mask;
                end
                exp_rd = v;
            end else if (sz == 2) begin
                exp_lat = 2 + w; exp_nreq = w + 1;
                ref_words[(a / 4) % 256] = wd;
            end else begin
                exp_lat = 3 + 2 * w; exp_nreq = 2 * w + 2;
                ref_words[(a / 4) % 256] = (word & ~(mask << shift)) | ((wd & mask) << shift);
            end
        end
    endtask

    int          lat, nreq, nwe, e_lat, e_nreq;
    logic [31:0] rd, e_rd;
    logic        er, e_err, aok;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0;
        bus2.req_valid = 0; bus2.req_store = 0; bus2.req_size = 0; bus2.req_unsigned = 0;
        bus2.req_addr = 0; bus2.req_wdata = 0; bus2.mem_ack = 0; bus2.mem_rdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem_words[i] = $urandom;
            ref_words[i] = mem_words[i];
        end

        vecs[0]  = '{0, 2'b00, 0, 32'h100, 32'h0,      32'h88223344, 32'hFFFFFF88, 0, 2, 1, 32'h88223344};
        vecs[1]  = '{0, 2'b00, 1, 32'h100, 32'h0,      32'h88223344, 32'h00000088, 0, 2, 1, 32'h88223344};
        vecs[2]  = '{0, 2'b01, 0, 32'h102, 32'h0,      32'h88223344, 32'h00003344, 0, 2, 1, 32'h88223344};
        vecs[3]  = '{0, 2'b01, 0, 32'h100, 32'h0,      32'h88223344, 32'hFFFF8822, 0, 2, 1, 32'h88223344};
        vecs[4]  = '{0, 2'b01, 1, 32'h100, 32'h0,      32'h88223344, 32'h00008822, 0, 2, 1, 32'h88223344};
        vecs[5]  = '{0, 2'b00, 0, 32'h103, 32'h0,      32'h88223344, 32'h00000044, 0, 2, 1, 32'h88223344};
        vecs[6]  = '{0, 2'b00, 0, 32'h101, 32'h0,      32'h11A23344, 32'hFFFFFFA2, 0, 2, 1, 32'h11A23344};
        vecs[7]  = '{1, 2'b00, 0, 32'h102, 32'hAB,     32'h11223344, 32'h0,        0, 3, 2, 32'h1122AB44};
        vecs[8]  = '{1, 2'b01, 0, 32'h102, 32'hBEEF,   32'h11223344, 32'h0,        0, 3, 2, 32'h1122BEEF};
        vecs[9]  = '{1, 2'b01, 0, 32'h101, 32'hBEEF,   32'h11223344, 32'h0,        1, 1, 0, 32'h11223344};
        vecs[10] = '{0, 2'b11, 0, 32'h100, 32'h0,      32'h11223344, 32'h0,        1, 1, 0, 32'h11223344};
        vecs[11] = '{0, 2'b10, 0, 32'h102, 32'h0,      32'h11223344, 32'h0,        1, 1, 0, 32'h11223344};
        vecs[12] = '{1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 32'h0,      32'h0,        0, 2, 1, 32'hDEADBEEF};
        vecs[13] = '{1, 2'b00, 0, 32'h100, 32'h1FF,    32'h11223344, 32'h0,        0, 3, 2, 32'hFF223344};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            mem_words[vecs[i].a[9:2]] = vecs[i].pre;
            ref_words[vecs[i].a[9:2]] = vecs[i].exp_word;
            run_txn(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, 0,
                    lat, nreq, nwe, rd, er, aok);
            $display("vec %0d st=%0d sz=%0d a=%h rdata=%h err=%0d lat=%0d nreq=%0d",
                     i, vecs[i].st, vecs[i].sz, vecs[i].a, rd, er, lat, nreq);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_nreq", i), 32'(nreq), 32'(vecs[i].exp_nreq));
            chk($sformatf("vec%0d_addr", i), 32'(aok), 32'd1);
            chk($sformatf("vec%0d_word", i), mem_words[vecs[i].a[9:2]], vecs[i].exp_word);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_hold", i), bus.resp_rdata, vecs[i].exp_rd);
        end

        // LW with 5 wait cycles.
        mem_words[8'h80] = 32'hA5A5_0F0F;
        ref_words[8'h80] = 32'hA5A5_0F0F;
        run_txn(0, 2'b10, 0, 32'h200, 32'h0, 5, lat, nreq, nwe, rd, er, aok);
        $display("lw_wait rdata=%h err=%0d lat=%0d nreq=%0d", rd, er, lat, nreq);
        chk("lw_wait_rdata", rd, 32'hA5A5_0F0F);
        chk("lw_wait_nreq", 32'(nreq), 32'd6);
        chk("lw_wait_lat", 32'(lat), 32'd7);
        chk("lw_wait_addr", 32'(aok), 32'd1);

        // SB that never gets an ack times out in RD and never writes.
        ref_words[8'h44] = mem_words[8'h44];
        run_txn(1, 2'b00, 0, 32'h111, 32'h5A, -1, lat, nreq, nwe, rd, er, aok);
        $display("sb_timeout rdata=%h err=%0d lat=%0d nreq=%0d nwe=%0d", rd, er, lat, nreq, nwe);
        chk("sb_to_err", 32'(er), 32'd1);
        chk("sb_to_rdata", rd, 32'd0);
        chk("sb_to_nreq", 32'(nreq), 32'd8);
        chk("sb_to_nwe", 32'(nwe), 32'd0);
        chk("sb_to_lat", 32'(lat), 32'd9);
        chk("sb_to_word", mem_words[8'h44], ref_words[8'h44]);

        // MAX_WAIT=4 instance: SW with ack tied low.
        @(posedge clk);
        #1;
        bus2.req_valid = 1; bus2.req_store = 1; bus2.req_size = 2'b10;
        bus2.req_addr = 32'h300; bus2.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus2.req_valid = 0;
        nreq = 0; lat = -1; rd = 32'hFFFF_FFFF; er = 0;
        for (int k = 1; k <= 50; k++) begin
            if (bus2.mem_req) nreq++;
            if (bus2.resp_valid) begin
                lat = k; rd = bus2.resp_rdata; er = bus2.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        $display("sw_timeout4 rdata=%h err=%0d lat=%0d nreq=%0d", rd, er, lat, nreq);
        chk("sw_to4_nreq", 32'(nreq), 32'd4);
        chk("sw_to4_lat", 32'(lat), 32'd5);
        chk("sw_to4_err", 32'(er), 32'd1);
        chk("sw_to4_rdata", rd, 32'd0);

        // Reset asserted during the WR phase of an SB.
        wait_cycles = 3;
        @(posedge clk);
        #1;
        bus.req_valid = 1; bus.req_store = 1; bus.req_size = 2'b00;
        bus.req_addr = 32'h121; bus.req_wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 0;
        nwe = 0;
        for (int k = 0; k < 50 && nwe == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.mem_we) nwe = 1;
        end
        chk("rst_mid_reached_wr", 32'(nwe), 32'd1);
        #2;
        rst = 1'b1;
        resp_cnt = 0;
        #1;
        chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_resp", 32'(resp_cnt), 32'd0);
        chk("rst_mid_word", mem_words[8'h48], ref_words[8'h48]);
        $display("rst_mid resp_cnt=%0d", resp_cnt);
        mem_words[8'h90] = 32'h0BAD_F00D;
        ref_words[8'h90] = 32'h0BAD_F00D;
        run_txn(0, 2'b10, 0, 32'h240, 32'h0, 0, lat, nreq, nwe, rd, er, aok);
        $display("lw_after_rst rdata=%h err=%0d lat=%0d", rd, er, lat);
        chk("lw_after_rst_rdata", rd, 32'h0BAD_F00D);
        chk("lw_after_rst_lat", 32'(lat), 32'd2);

        // Random traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic        st, uns;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            int          w, r;
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            st = 1'($urandom);
            uns = 1'($urandom);
            a = 32'h100 + $urandom_range(0, 63);
            wd = $urandom;
            w = $urandom_range(0, 3);
            model(st, sz, uns, a, wd, w, e_rd, e_err, e_lat, e_nreq);
            run_txn(st, sz, uns, a, wd, w, lat, nreq, nwe, rd, er, aok);
            $display("rnd %0d st=%0d sz=%0d uns=%0d a=%h wd=%h w=%0d rdata=%h err=%0d lat=%0d",
                     n, st, sz, uns, a, wd, w, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(e_err));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(e_lat));
            chk($sformatf("rnd%0d_nreq", n), 32'(nreq), 32'(e_nreq));
            chk($sformatf("rnd%0d_word", n), mem_words[a[9:2]], ref_words[a[9:2]]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_sub_word_ctrl.md
# mem_sub_word_ctrl

Sequencer between the MEM pipeline stage and the word-organised data memory. It turns byte, halfword and word loads/stores into word-wide memory transactions. Sub-word stores become read-modify-write: read the word, merge, write it back. Byte order is big-endian: byte offset 0 is bits [31:24]. The block also extracts and sign/zero-extends load data and reports misaligned accesses and memory timeouts.

## Interface
- MAX_WAIT, 255, maximum cycles a single memory transaction may wait for mem_ack (>=1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  access request from MEM stage; held until accepted
- req_ready  out  1  high only in IDLE; accept = req_valid && req_ready at clk edge
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and words
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or timeout
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors
- mem_req  out  1  memory transaction active
- mem_we  out  1  1 = write transaction
- mem_addr  out  30  word address (req_addr[31:2])
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid when mem_ack && !mem_we
- mem_ack  in  1  transaction complete this cycle

## Operation
- All request fields are registered at acceptance and held to RESP. The requester may change them after acceptance.
- FSM states: IDLE, RD, WR, RESP.
- IDLE, at accept:
  - misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> RESP, err=1.
  - load -> RD.
  - word store -> WR with mem_wdata = wdata.
  - sub-word store -> RD.
- RD: mem_req=1, mem_we=0. On mem_ack: a load captures the extracted result and goes to RESP. A sub-word store captures the merged word into the write register and goes to WR.
- WR: mem_req=1, mem_we=1. On mem_ack -> RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Byte lane, b = addr[1:0]: bits [31-8b : 24-8b]. Half lane, addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
- Load extract: the lane value is sign-extended from its MSB, or zero-extended when req_unsigned=1. A word load passes through unchanged.
- Store merge: the target lane is replaced with wdata[7:0] or wdata[15:0]. Other lanes keep mem_rdata.
- Timeout: a wait counter (width clog2(MAX_WAIT+1)) clears on entry to RD and on entry to WR. It increments on each RD/WR cycle without mem_ack. If mem_ack is low in the cycle the counter equals MAX_WAIT-1, go to RESP with err=1 and rdata=0. An ack in that same cycle wins over the timeout. A sub-word store that times out in RD never enters WR.
- req_valid outside IDLE is ignored, with no queuing.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter 0.
- Reset mid-operation aborts immediately. mem_req deasserts asynchronously with rst, no resp_valid is produced, and the FSM is in IDLE on the first edge after release.
- mem_addr, mem_we and mem_wdata are stable for every cycle mem_req=1.
- mem_req is high for at least one cycle per transaction and drops in the cycle after mem_ack. There are no idle cycles between RD and WR of a read-modify-write.
- With a zero-wait memory (ack in the first mem_req cycle), counting from the accept edge E0:
  - load / SW: state at E0+1 is RD/WR, resp_valid in cycle E0+2.
  - SB/SH: RD at E0+1, WR at E0+2, resp_valid at E0+3.
  - error: resp_valid at E0+1, with no mem_req.
- Each wait cycle adds one cycle to the corresponding transaction.
- resp_rdata and resp_err hold their values until the next RESP.

## Test plan
- Word 0x88223344 at 0x100: LB 0x100 -> resp_rdata 0xFFFFFF88. LBU 0x100 -> 0x00000088. LH 0x102 -> 0x00003344.
- Word 0x11223344 at 0x100, SB addr 0x102 wdata 0xAB, zero-wait -> read 0x40, then write 0x1122AB44; resp_valid at E0+3, resp_err=0.
- SH addr 0x102 wdata 0xBEEF -> word 0x1122BEEF. SH addr 0x101 -> resp_err=1 at E0+1, mem_req never asserted.
- LW 0x200 with mem_ack after 5 wait cycles -> mem_req high 6 cycles, mem_addr 0x80 stable, resp_valid the cycle after ack.
- MAX_WAIT=4, SW with mem_ack tied low -> mem_req high exactly 4 cycles, then resp_valid with resp_err=1, resp_rdata=0.
- rst pulsed during WR of an SB -> mem_req low in the same cycle, no resp_valid, req_ready=1; the next LW completes normally.
